// File: rtl/fnd_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fnd_scan_driver: binary count -> BCD (sequential double dabble) ->       |
// | 4-digit common-anode 7-segment scan, shown as "XXX.X".                   |
// | Optional leading-zero blanking when FND_LZB_EN is defined.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fnd_scan_driver #(
    parameter int SCAN_DIV = 100_000,
    parameter int MAX_VAL  = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] i_count,
    output logic [3:0]  o_fnd_com,
    output logic [7:0]  o_fnd_font,
    output logic        o_busy,
    output logic        o_ovf
);
    localparam int                C_SCAN_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [C_SCAN_W-1:0] C_SCAN_LAST = C_SCAN_W'(SCAN_DIV - 1);
    localparam logic [13:0]       C_MAX       = 14'(MAX_VAL);
    localparam logic [3:0]        C_LAST_ITER = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [13:0]         r_last;
    logic [29:0]         r_shift;
    logic [3:0]          r_iter;
    logic                r_ovf_pend;
    logic [15:0]         r_disp;
    logic [C_SCAN_W-1:0] r_scan_cnt;
    logic [1:0]          r_idx;
    logic                r_scan_on;
    logic [3:0]          r_com;
    logic [7:0]          r_font;
    logic                r_busy;
    logic                r_ovf;

    logic [29:0]         w_dabble;
    logic                w_wrap;
    logic                w_on_nxt;
    logic [1:0]          w_idx_nxt;
    logic [3:0]          w_digit;
    logic [7:0]          w_font;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 8'hC0;
            4'd1:    seg_of = 8'hF9;
            4'd2:    seg_of = 8'hA4;
            4'd3:    seg_of = 8'hB0;
            4'd4:    seg_of = 8'h99;
            4'd5:    seg_of = 8'h92;
            4'd6:    seg_of = 8'h82;
            4'd7:    seg_of = 8'hF8;
            4'd8:    seg_of = 8'h80;
            4'd9:    seg_of = 8'h90;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    // One double-dabble step: BCD lives in [29:14], binary in [13:0].
    always_comb begin
        w_dabble = r_shift;
        for (int i = 0; i < 4; i++) begin
            if (w_dabble[14 + 4*i +: 4] >= 4'd5)
                w_dabble[14 + 4*i +: 4] = w_dabble[14 + 4*i +: 4] + 4'd3;
        end
        w_dabble = {w_dabble[28:0], 1'b0};
    end

    // First wrap only switches the display on at digit 0; later wraps advance.
    always_comb begin
        w_wrap    = (r_scan_cnt == C_SCAN_LAST);
        w_on_nxt  = r_scan_on | w_wrap;
        w_idx_nxt = (w_wrap && r_scan_on) ? r_idx + 2'd1 : r_idx;
        w_digit   = r_disp[{w_idx_nxt, 2'b00} +: 4];
        w_font    = seg_of(w_digit);
`ifdef FND_LZB_EN
        if ((w_idx_nxt == 2'd3 && r_disp[15:12] == 4'd0) ||
            (w_idx_nxt == 2'd2 && r_disp[15:8] == 8'd0))
            w_font = 8'hFF;
`endif
        if (w_idx_nxt == 2'd1)
            w_font[7] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_last     <= '0;
            r_shift    <= '0;
            r_iter     <= '0;
            r_ovf_pend <= 1'b0;
            r_disp     <= '0;
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_scan_on  <= 1'b0;
            r_com      <= 4'b1111;
            r_font     <= 8'hFF;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_count != r_last) begin
                        r_last     <= i_count;
                        r_shift    <= {16'd0, (i_count > C_MAX) ? C_MAX : i_count};
                        r_ovf_pend <= (i_count > C_MAX);
                        r_iter     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_dabble;
                    r_iter  <= r_iter + 4'd1;
                    if (r_iter == C_LAST_ITER)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_disp  <= r_shift[29:14];
                    r_ovf   <= r_ovf_pend;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + 1'b1;
            r_scan_on  <= w_on_nxt;
            r_idx      <= w_idx_nxt;
            if (w_on_nxt) begin
                r_com  <= ~(4'b0001 << w_idx_nxt);
                r_font <= w_font;
            end
        end
    end

    assign o_fnd_com  = r_com;
    assign o_fnd_font = r_font;
    assign o_busy     = r_busy;
    assign o_ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_driver.sv
`default_nettype none
// Testbench for fnd_scan_driver: cycle-level reference model plus directed
// literal checks of digit fonts, busy window, overflow and reset abort.
module tb_fnd_scan_driver;
    localparam int SCAN_DIV = 4;
    localparam int MAX_VAL  = 9999;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [13:0] i_count = 14'd0;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_font;
    logic        o_busy;
    logic        o_ovf;

    int checks = 0;
    int errors = 0;
    bit tb_done = 1'b0;

    fnd_scan_driver #(.SCAN_DIV(SCAN_DIV), .MAX_VAL(MAX_VAL)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_count    (i_count),
        .o_fnd_com  (o_fnd_com),
        .o_fnd_font (o_fnd_font),
        .o_busy     (o_busy),
        .o_ovf      (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg(input int d);
        case (d)
            0: seg = 8'hC0;  1: seg = 8'hF9;  2: seg = 8'hA4;  3: seg = 8'hB0;
            4: seg = 8'h99;  5: seg = 8'h92;  6: seg = 8'h82;  7: seg = 8'hF8;
            8: seg = 8'h80;  9: seg = 8'h90;  default: seg = 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_font(input int disp, input int idx);
        int div;
        logic [7:0] f;
        div = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        f = seg((disp / div) % 10);
`ifdef FND_LZB_EN
        if ((idx == 3 && disp < 1000) || (idx == 2 && disp < 100))
            f = 8'hFF;
`endif
        if (idx == 1)
            f[7] = 1'b0;
        return f;
    endfunction

    // Reference model: job latency 15 edges, display = decimal digits of value.
    int         m_k, m_cnt, m_disp, m_target, m_last;
    bit         m_pend, m_ovf, m_valid;
    logic [3:0] e_com;
    logic [7:0] e_font;
    logic       e_busy, e_ovf;

    initial begin : p_model
        int old_disp, slot, idx;
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_valid = 1'b1;
                m_k = 0; m_cnt = 0; m_disp = 0; m_last = 0; m_ovf = 1'b0;
                e_com = 4'b1111; e_font = 8'hFF; e_busy = 1'b0; e_ovf = 1'b0;
            end else if (m_valid) begin
                old_disp = m_disp;
                m_k++;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_disp = m_target;
                        m_ovf  = m_pend;
                    end
                end else if (int'(i_count) != m_last) begin
                    m_last   = int'(i_count);
                    m_pend   = (int'(i_count) > MAX_VAL);
                    m_target = m_pend ? MAX_VAL : int'(i_count);
                    m_cnt    = 15;
                end
                slot = m_k / SCAN_DIV;
                if (slot == 0) begin
                    e_com  = 4'b1111;
                    e_font = 8'hFF;
                end else begin
                    idx    = (slot - 1) % 4;
                    e_com  = ~(4'b0001 << idx);
                    e_font = exp_font(old_disp, idx);
                end
                e_busy = (m_cnt > 0);
                e_ovf  = m_ovf;
            end
        end
    end

    initial begin : p_compare
        forever begin
            @(negedge clk);
            if (m_valid && !tb_done) begin
                chk("model_com",  o_fnd_com,  e_com);
                chk("model_font", o_fnd_font, e_font);
                chk("model_busy", o_busy,     e_busy);
                chk("model_ovf",  o_ovf,      e_ovf);
            end
        end
    end

    task automatic wait_rise();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_busy) break;
        end
        chk("busy_rise", o_busy, 1);
    endtask

    task automatic wait_done(output int busy_cycles);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_busy) begin
                seen = 1'b1;
                n++;
            end else if (seen) begin
                break;
            end
        end
        busy_cycles = n;
        chk("conv_seen", seen, 1);
        chk("conv_end", o_busy, 0);
    endtask

    task automatic chk_digit(input int idx, input logic [7:0] expf, input string name);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        for (int i = 0; i < 12 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (o_fnd_com == want) break;
        end
        chk({name, "_com"}, o_fnd_com, want);
        chk(name, o_fnd_font, expf);
    endtask

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int n;
        logic [7:0] e;
`ifdef FND_LZB_EN
        logic [7:0] z_hi = 8'hFF;
`else
        logic [7:0] z_hi = 8'hC0;
`endif

        // 1: reset, then scan start-up with value 0
        reset = 1'b0;
        i_count = 14'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk("boot_com_off", o_fnd_com, 4'b1111);
                chk("boot_font_off", o_fnd_font, 8'hFF);
            end else if (k == 4) begin
                chk("boot_com0", o_fnd_com, 4'b1110);
                chk("boot_font0", o_fnd_font, 8'hC0);
            end else if (k == 8) begin
                chk("boot_com1", o_fnd_com, 4'b1101);
                chk("boot_font1", o_fnd_font, 8'h40);
            end else if (k == 12) begin
                chk("boot_com2", o_fnd_com, 4'b1011);
                chk("boot_font2", o_fnd_font, z_hi);
            end else if (k == 16) begin
                chk("boot_com3", o_fnd_com, 4'b0111);
                chk("boot_font3", o_fnd_font, z_hi);
            end
        end

        // 2: 1234
        i_count = 14'd1234;
        wait_done(n);
        chk("busy_len_1234", n, 15);
        chk("ovf_1234", o_ovf, 0);
        chk_digit(0, 8'h99, "d0_1234");
        chk_digit(1, 8'h30, "d1_1234");
        chk_digit(2, 8'hA4, "d2_1234");
        chk_digit(3, 8'hF9, "d3_1234");

        // 3: saturation, then recovery
        i_count = 14'd12000;
        wait_done(n);
        chk("ovf_12000", o_ovf, 1);
        chk_digit(0, 8'h90, "d0_sat");
        chk_digit(1, 8'h10, "d1_sat");
        chk_digit(2, 8'h90, "d2_sat");
        chk_digit(3, 8'h90, "d3_sat");
        i_count = 14'd9999;
        wait_done(n);
        chk("ovf_9999", o_ovf, 0);
        i_count = 14'd42;
        wait_done(n);
        chk("ovf_42", o_ovf, 0);

        // 4: input change in the middle of a conversion
        i_count = 14'd1234;
        wait_rise();
        repeat (4) @(negedge clk);
        i_count = 14'd5678;
        for (int i = 0; i < 30; i++) begin
            if (!o_busy) break;
            @(negedge clk);
        end
        chk("first_done", o_busy, 0);
        @(negedge clk);
        chk("restart_busy", o_busy, 1);
        case (o_fnd_com)
            4'b1110: e = 8'h99;
            4'b1101: e = 8'h30;
            4'b1011: e = 8'hA4;
            4'b0111: e = 8'hF9;
            default: e = 8'h00;
        endcase
        chk("shown_1234_first", o_fnd_font, e);
        wait_done(n);
        chk_digit(0, 8'h80, "d0_5678");
        chk_digit(1, 8'h78, "d1_5678");
        chk_digit(2, 8'h82, "d2_5678");
        chk_digit(3, 8'h92, "d3_5678");

        // 5: reset during conversion of 777
        i_count = 14'd777;
        wait_rise();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_com", o_fnd_com, 4'b1111);
        chk("rst_font", o_fnd_font, 8'hFF);
        chk("rst_ovf", o_ovf, 0);
        reset = 1'b1;
        wait_done(n);
        chk("busy_len_777", n, 15);
        chk_digit(0, 8'hF8, "d0_777");
        chk_digit(1, 8'h78, "d1_777");
        chk_digit(2, 8'hF8, "d2_777");
        chk_digit(3, z_hi,  "d3_777");

        // 6: small value, leading digits
        i_count = 14'd5;
        wait_done(n);
        chk_digit(0, 8'h92, "d0_5");
        chk_digit(1, 8'h40, "d1_5");
        chk_digit(2, z_hi,  "d2_5");
        chk_digit(3, z_hi,  "d3_5");

        tb_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
